// File: rtl/modulo_entrada_chave_pkg.sv
// modulo_entrada_pkg
//   Shared definitions for the switch-input path: debouncer FSM state
//   encoding, default debounce length and the switch word width.
package modulo_entrada_pkg;

  // Data width of the switch bank / processor input word.
  localparam int unsigned DATA_W = 16;

  // Default debounce length: 5 ms at 50 MHz.
  localparam int unsigned DEB_CYCLES_DEF = 250000;

  // Debouncer FSM states.
  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,  // released, waiting for a press
    FILTRA_PRESS = 2'd1,  // press seen, waiting for it to be stable
    SEGURA       = 2'd2,  // press accepted, button held
    FILTRA_SOLTA = 2'd3   // release seen, waiting for it to be stable
  } estado_t;

endpackage

// File: rtl/modulo_entrada_chave_filtro_botao.sv
// filtro_botao
//   Conditions the raw active-low push-button: 2-FF synchronizer, then a
//   debounce FSM with a saturating counter. Produces the debounced level and
//   a one-clk capture pulse per accepted press.
//
//   Ports:
//     clk      in   board clock
//     reset    in   asynchronous, active-low
//     ent      in   raw button, active-low (0 = pressed), asynchronous
//     pressed  out  debounced level, 1 = pressed (registered)
//     captura  out  one-clk pulse in the cycle the press is accepted
//                   (combinational from the FSM state, so storage loads on
//                   the same edge that sets pressed)
module filtro_botao
  import modulo_entrada_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned DEB_W      = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic ent,
  output logic pressed,
  output logic captura
);

  if (DEB_CYCLES < 1 || 64'(DEB_CYCLES) >= (64'd1 << DEB_W)) begin : g_chk_deb
    $error("DEB_CYCLES must be >= 1 and fit in DEB_W bits");
  end

  localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_ent_s;
  estado_t          r_estado;
  estado_t          w_estado_prox;
  logic [DEB_W-1:0] r_cnt;
  logic [DEB_W-1:0] w_cnt_prox;
  logic             r_pressed;
  logic             w_pressed_prox;
  logic             w_captura;

  // Synchronizer resets to the released level so a reset never looks like
  // a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ent;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ent_s = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado  <= OCIOSO;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_cnt     <= w_cnt_prox;
      r_pressed <= w_pressed_prox;
    end
  end

  // The counter leaves each filter state on reaching CNT_MAX, so it can
  // never wrap.
  always_comb begin
    w_estado_prox  = r_estado;
    w_cnt_prox     = r_cnt;
    w_pressed_prox = r_pressed;
    w_captura      = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (!w_ent_s) begin
          w_cnt_prox    = '0;
          w_estado_prox = FILTRA_PRESS;
        end
      end
      FILTRA_PRESS: begin
        if (w_ent_s) begin
          w_estado_prox = OCIOSO;
        end else if (r_cnt == CNT_MAX) begin
          w_captura      = 1'b1;
          w_pressed_prox = 1'b1;
          w_estado_prox  = SEGURA;
        end else begin
          w_cnt_prox = r_cnt + DEB_W'(1);
        end
      end
      SEGURA: begin
        if (w_ent_s) begin
          w_cnt_prox    = '0;
          w_estado_prox = FILTRA_SOLTA;
        end
      end
      FILTRA_SOLTA: begin
        if (!w_ent_s) begin
          w_estado_prox = SEGURA;
        end else if (r_cnt == CNT_MAX) begin
          w_pressed_prox = 1'b0;
          w_estado_prox  = OCIOSO;
        end else begin
          w_cnt_prox = r_cnt + DEB_W'(1);
        end
      end
      default: w_estado_prox = OCIOSO;
    endcase
  end

  assign pressed = r_pressed;
  assign captura = w_captura;

endmodule

// File: rtl/modulo_entrada_chave.sv
// modulo_entrada_chave
//   Producer end of the switch-input path. Debounces the active-low `ent`
//   button (filtro_botao), captures `switch` once per accepted press and
//   presents it to the processor with a valid / rd handshake.
//
//   Build option: macro ENTRADA_FILA_EN
//     undefined - single holding register
//     defined   - FIFO_DEPTH-word circular buffer (power of two)
//
//   Ports:
//     clk      in   board clock
//     reset    in   asynchronous, active-low
//     ent      in   raw button, active-low, asynchronous
//     switch   in   16-bit switch bank, sampled at capture
//     rd       in   one-clk read strobe, consumes the presented word
//     valid    out  a word is available on data
//     data     out  presented word (FIFO head when the FIFO is enabled)
//     overrun  out  sticky, a press was lost because storage was full;
//                   cleared by the next consuming rd
//     pressed  out  debounced button level
module modulo_entrada_chave
  import modulo_entrada_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned DEB_W      = 18,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ent,
  input  logic [DATA_W-1:0] switch,
  input  logic              rd,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              overrun,
  output logic              pressed
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic w_captura;

  filtro_botao #(
    .DEB_CYCLES(DEB_CYCLES),
    .DEB_W     (DEB_W)
  ) u_filtro (
    .clk    (clk),
    .reset  (reset),
    .ent    (ent),
    .pressed(pressed),
    .captura(w_captura)
  );

`ifdef ENTRADA_FILA_EN

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overrun;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = rd && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign w_push = w_captura && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= switch;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_overrun <= 1'b0;
      end else if (w_captura && w_full) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign valid   = (r_count != '0);
  assign data    = r_mem[r_rptr];
  assign overrun = r_overrun;

`else

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;
  logic              w_rd_ok;

  assign w_rd_ok = rd && r_valid;

  // A read in the capture cycle frees the register, so the new word loads
  // and valid stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_captura && (!r_valid || w_rd_ok)) begin
        r_data  <= switch;
        r_valid <= 1'b1;
      end else if (w_rd_ok) begin
        r_valid <= 1'b0;
      end
      if (w_rd_ok) begin
        r_overrun <= 1'b0;
      end else if (w_captura && r_valid) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign valid   = r_valid;
  assign data    = r_data;
  assign overrun = r_overrun;

`endif

endmodule

// File: tb/tb_modulo_entrada_chave.sv
module tb_modulo_entrada_chave;

  logic        clk = 1'b0;
  logic        reset;
  logic        ent;
  logic [15:0] switch;
  logic        rd;
  logic        valid;
  logic [15:0] data;
  logic        overrun;
  logic        pressed;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];

  modulo_entrada_chave #(
    .DEB_CYCLES(4),
    .DEB_W     (3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ent    (ent),
    .switch (switch),
    .rd     (rd),
    .valid  (valid),
    .data   (data),
    .overrun(overrun),
    .pressed(pressed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press held 10 clk then released long enough for the release filter.
  task automatic press(input logic [15:0] w, input bit expect_store);
    if (expect_store) exp_q.push_back(w);
    switch = w;
    ent    = 1'b0;
    tick(10);
    ent    = 1'b1;
    tick(12);
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  // Scoreboard monitor: a transfer occurs on the edge after a negedge that
  // sees rd and valid together.
  always @(negedge clk) begin
    if (reset === 1'b1 && rd === 1'b1 && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL transfer: got word %0h, expected none pending", data);
      end else begin
        chk("transfer", {16'h0, data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit bad;
    reset  = 1'b0;
    ent    = 1'b1;
    switch = '0;
    rd     = 1'b0;
    #1;
    chk("reset valid", valid, 0);
    chk("reset data", data, 0);
    chk("reset overrun", overrun, 0);
    chk("reset pressed", pressed, 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // Clean press: capture on the 7th edge after ent falls.
    exp_q.push_back(16'hA5C3);
    switch = 16'hA5C3;
    ent    = 1'b0;
    tick(6);
    chk("clean valid before capture", valid, 0);
    tick(1);
    chk("clean valid", valid, 1);
    chk("clean data", data, 16'hA5C3);
    chk("clean pressed", pressed, 1);
    tick(3);
    ent = 1'b1;
    tick(12);
    chk("clean released", pressed, 0);
    chk("clean overrun", overrun, 0);
    rd_pulse();
    chk("clean valid after rd", valid, 0);
    chk("clean data kept", data, 16'hA5C3);
    tick(3);
    chk("clean no repeat", valid, 0);

    // Bounce: never stable for 4 filtered cycles.
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ent = 1'b0;
      repeat (2) begin
        tick(1);
        if (valid !== 1'b0 || pressed !== 1'b0) bad = 1'b1;
      end
      ent = 1'b1;
      repeat (2) begin
        tick(1);
        if (valid !== 1'b0 || pressed !== 1'b0) bad = 1'b1;
      end
    end
    tick(10);
    chk("bounce quiet", {bad, valid, pressed}, 3'b000);

`ifdef ENTRADA_FILA_EN
    // FIFO: fifth press dropped.
    for (int i = 1; i <= 5; i++) press(16'(i), i <= 4);
    chk("fifo overrun", overrun, 1);
    chk("fifo valid", valid, 1);
    chk("fifo head", data, 16'h0001);
    rd_pulse();
    chk("fifo overrun cleared", overrun, 0);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      rd_pulse();
      tick(1);
    end
    chk("fifo empty", valid, 0);
`else
    // Overrun with single register.
    press(16'h0001, 1'b1);
    press(16'h0002, 1'b0);
    chk("ovr data", data, 16'h0001);
    chk("ovr flag", overrun, 1);
    rd_pulse();
    chk("ovr valid after rd", valid, 0);
    chk("ovr flag after rd", overrun, 0);
`endif

    // Simultaneous capture and rd.
    press(16'h0001, 1'b1);
    exp_q.push_back(16'h0002);
    switch = 16'h0002;
    ent    = 1'b0;
    tick(6);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    chk("simul valid", valid, 1);
    chk("simul data", data, 16'h0002);
    chk("simul overrun", overrun, 0);
    tick(3);
    ent = 1'b1;
    tick(12);
    rd_pulse();
    chk("simul drained", valid, 0);

    // Reset in FILTRA_PRESS at count 2, with an unread word pending.
    press(16'h1234, 1'b0);
    switch = 16'h5A5A;
    ent    = 1'b0;
    tick(5);
    reset = 1'b0;
    #1;
    chk("midreset valid", valid, 0);
    chk("midreset data", data, 0);
    chk("midreset overrun", overrun, 0);
    chk("midreset pressed", pressed, 0);
    tick(2);
    reset = 1'b1;
    tick(6);
    chk("postreset no early capture", valid, 0);
    exp_q.push_back(16'h5A5A);
    tick(1);
    chk("postreset valid", valid, 1);
    chk("postreset pressed", pressed, 1);
    ent = 1'b1;
    tick(12);
    rd_pulse();
    chk("postreset drained", valid, 0);

    tick(2);
    chk("scoreboard empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modulo_entrada_chave.md
Name: modulo_entrada_chave

Overview:
Producer end of the processor's switch-input path: it delivers 16-bit words from the board switches to the processor's input instruction. Conditions the raw, active-low `ent` push-button (sync + debounce), captures `switch` once per confirmed press, and presents the word with a valid/read handshake. Runs on the fast board clock. The processor core consumes `data` with a single-cycle `rd` strobe instead of edge-detecting `ent` itself.

Parameters:
DEB_CYCLES, 250000, clk cycles the synchronized `ent` must be stable before a press or release is accepted (5 ms at 50 MHz).
DEB_W, 18, width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES.
FIFO_DEPTH, 4, word depth when ENTRADA_FILA_EN is defined (power of two); ignored otherwise.

Ports:
clk  in  1  board clock.
reset  in  1  asynchronous, active-low.
ent  in  1  raw push-button, active-low (0 = pressed), asynchronous to clk.
switch  in  16  raw switch bank, quasi-static.
rd  in  1  processor read strobe, one clk wide; consumes the presented word.
valid  out  1  a captured word is available on `data`.
data  out  16  presented word (FIFO head when the FIFO is enabled).
overrun  out  1  sticky; a press was lost because storage was full.
pressed  out  1  debounced button level (1 = pressed), for LEDs/debug.

Behaviour:
- Reset (async, reset=0): all outputs 0; FSM in OCIOSO; synchronizer flops to 1 (released); counter 0. Assertion mid-debounce or mid-handshake discards everything.
- Synchronizer: 2-FF chain on `ent` giving ent_s. `switch` is sampled directly at capture; it is assumed stable while the button is held.
- FSM states:
  - OCIOSO: ent_s=1. When ent_s=0: clear counter, go to FILTRA_PRESS.
  - FILTRA_PRESS: counter increments while ent_s=0. If ent_s returns to 1 before terminal count, go back to OCIOSO with no capture. When the counter reaches DEB_CYCLES-1 with ent_s=0: generate a capture pulse, set pressed=1, go to SEGURA.
  - SEGURA: wait for ent_s=1. Then clear counter, go to FILTRA_SOLTA.
  - FILTRA_SOLTA: counter increments while ent_s=1. If ent_s returns to 0, go back to SEGURA. At terminal count, set pressed=0 and go to OCIOSO.
- Exactly one capture per debounced press. Holding the button never repeats the capture.
- Capture pulse, single register (no FIFO):
  - If valid=0: data<=switch and valid<=1 on the next edge. Latency from the final stable ent_s sample is 1 clk.
  - If valid=1 and rd=0: data is kept, the new word is dropped, overrun<=1.
  - If valid=1 and rd=1 in the same cycle: the old word is consumed, the new word is loaded, valid stays 1, no overrun.
- rd handling:
  - rd with valid=1: valid<=0 next edge and overrun<=0.
  - rd with valid=0: ignored, no state change.
  - rd held for several cycles consumes only what is present in each cycle.
- data holds its last value after consumption; it is not cleared.
- Counter never wraps: it saturates at DEB_CYCLES-1.

Optional Feature:
ENTRADA_FILA_EN:
- Defined: captures push into a FIFO_DEPTH circular buffer with log2 read/write pointers plus a count.
  - valid = count≠0; data = mem[rd_ptr]; rd pops.
  - Capture while full and no rd: dropped, overrun<=1.
  - Capture and rd in the same cycle while full: both happen, count unchanged.
  - overrun clears on the next rd.
- Undefined: single-register behaviour described above.

Decomposition:
- Package modulo_entrada_pkg: FSM state encoding (OCIOSO=2'd0, FILTRA_PRESS=2'd1, SEGURA=2'd2, FILTRA_SOLTA=2'd3), default DEB_CYCLES constant, data width 16.
- Sub-module filtro_botao: synchronizer + counter + FSM, producing pressed and the one-clk capture pulse. The top level holds the storage/handshake logic (register or FIFO).

Test Plan (DEB_CYCLES=4):
- Clean press: ent=0 for 10 clk with switch=16'hA5C3 -> exactly one capture, valid=1, data=A5C3, pressed=1; rd pulse -> valid=0 next clk, data still A5C3.
- Bounce: ent toggles 0/1 every 2 clk for 20 clk, then stays 1 -> valid stays 0 and pressed stays 0 throughout.
- Overrun, no FIFO: press with 16'h0001, no rd, then press with 16'h0002 -> data=0001, overrun=1; rd -> valid=0, overrun=0.
- Simultaneous: second capture lands in the same cycle as rd -> valid stays 1, data=0002, overrun=0.
- FIFO (ENTRADA_FILA_EN): 5 presses with 1..5, no rd -> overrun=1; four rd pulses return 1,2,3,4, then valid=0.
- Reset mid-FILTRA_PRESS: reset=0 at count 2 -> all outputs 0; after release of reset, ent held 0 needs a full 4 stable cycles before capture.
